// File: rtl/pin_sampler_pkg.sv
// Shared widths, word layout and FSM encoding for the probe-pin sampler.
// Every word leaving the sampler is {seq, sample}, with the sequence tag in the top nibble.
package pin_sampler_pkg;

    localparam int SAMPLE_W = 12;
    localparam int SEQ_W    = 4;
    localparam int WORD_W   = 16;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [SEQ_W-1:0]    seq_t;
    typedef logic [WORD_W-1:0]   word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    function automatic word_t pack_word(input seq_t seq, input sample_t sample);
        return {seq, sample};
    endfunction

endpackage

// File: rtl/pin_sampler_fifo_sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head word is presented on dout whenever it is not empty.
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module sync_fifo_fwft #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_ok, rd_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == (AW+1)'(DEPTH));
    assign rd_ok = pop && !empty;
    assign wr_ok = push && (!full || rd_ok);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/pin_sampler_fifo.sv
// Samples the synchronized probe pins on each prescaler tick, tags them with a sequence
// number and queues them for the SPI slave; an overflow halts capture until re-armed.
module pin_sampler_fifo
    import pin_sampler_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int DEPTH       = 16,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SAMPLE_W-1:0]      d_in,
    input  logic                     arm,
    input  logic                     stop,
    input  logic                     rd_en,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     running
);

    sample_t sync1_q, sync2_q;
    sample_t last_q, last_d;
    seq_t    seq_q, seq_d;
    state_e  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic    ovf_q, ovf_d;

    logic    in_run, tick, want_push, push_ok, pop_ok, drop, arm_ok, fifo_rst;
    logic    fifo_empty, fifo_full;
    word_t   fifo_dout;

    assign in_run    = (state_q == RUN);
    assign tick      = in_run && (presc_q == 16'(CLK_DIV - 1));
    assign want_push = tick && (!CHANGE_ONLY || (sync2_q != last_q));
    assign pop_ok    = rd_en && !fifo_empty;
    assign push_ok   = want_push && (!fifo_full || pop_ok);
    assign drop      = want_push && fifo_full && !pop_ok;
    assign arm_ok    = arm && !stop && !in_run;
    // Re-arming discards whatever the previous capture left behind.
    assign fifo_rst  = rst || arm_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arm && !stop) state_d = RUN;
            RUN: begin
                if (stop)      state_d = IDLE;
                else if (drop) state_d = HALT;
            end
            HALT: begin
                if (stop)     state_d = IDLE;
                else if (arm) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        seq_d   = seq_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        presc_d = presc_q;
        if (arm_ok) begin
            seq_d  = '0;
            last_d = sync2_q;
            ovf_d  = 1'b0;
        end else begin
            if (push_ok) begin
                seq_d  = seq_q + SEQ_W'(1);
                last_d = sync2_q;
            end
            if (drop) ovf_d = 1'b1;
        end
        // The count only advances while capture continues into the next cycle.
        if (!in_run || (state_d != RUN) || tick) presc_d = '0;
        else                                     presc_d = presc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            seq_q   <= '0;
            last_q  <= '0;
            presc_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            seq_q   <= seq_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            ovf_q   <= ovf_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (fifo_rst),
        .push  (push_ok),
        .din   (pack_word(seq_q, sync2_q)),
        .pop   (pop_ok),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (level)
    );

    assign rd_data  = fifo_dout;
    assign rd_valid = !fifo_empty;
    assign overflow = ovf_q;
    assign running  = in_run;

endmodule

// File: tb/tb_pin_sampler_fifo.sv
// Bench for pin_sampler_fifo: three instances (div 4, div 1, div 1 change-only) share stimulus
// and are compared against a queue-based reference model plus directed expected words.
module tb_pin_sampler_fifo;

    localparam int N     = 3;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst, arm, stop, rd_en;
    logic [11:0] d_in;

    logic [15:0]   rd_data  [N];
    logic          rd_valid [N];
    logic [LW-1:0] level    [N];
    logic          overflow [N];
    logic          running  [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pin_sampler_fifo #(.CLK_DIV(4), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dut_div4 (
        .clk(clk), .rst(rst), .d_in(d_in), .arm(arm), .stop(stop), .rd_en(rd_en),
        .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .level(level[0]),
        .overflow(overflow[0]), .running(running[0]));

    pin_sampler_fifo #(.CLK_DIV(1), .DEPTH(DEPTH), .CHANGE_ONLY(1'b0)) dut_div1 (
        .clk(clk), .rst(rst), .d_in(d_in), .arm(arm), .stop(stop), .rd_en(rd_en),
        .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .level(level[1]),
        .overflow(overflow[1]), .running(running[1]));

    pin_sampler_fifo #(.CLK_DIV(1), .DEPTH(DEPTH), .CHANGE_ONLY(1'b1)) dut_chg (
        .clk(clk), .rst(rst), .d_in(d_in), .arm(arm), .stop(stop), .rd_en(rd_en),
        .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .level(level[2]),
        .overflow(overflow[2]), .running(running[2]));

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_e;
    mstate_e     m_st   [N];
    int          m_cnt  [N];
    int          m_seq  [N];
    logic [11:0] m_last [N];
    logic        m_ovf  [N];
    logic [11:0] p1 = '0, p2 = '0;
    logic [15:0] q0[$], q1[$], q2[$];

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic bit change_of(input int k);
        return (k == 2);
    endfunction

    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [15:0] q_head(input int k);
        if (q_size(k) == 0) return 16'h0;
        case (k)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void q_push(input int k, input logic [15:0] w);
        case (k)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endfunction

    function automatic void q_pop(input int k);
        case (k)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void q_clear(input int k);
        case (k)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    always @(posedge clk) begin
        bit m_tick, m_want, m_pop, m_full, m_drop;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_st[k] = M_IDLE; m_cnt[k] = 0; m_seq[k] = 0;
                m_last[k] = '0; m_ovf[k] = 1'b0; q_clear(k);
            end
            p1 = '0; p2 = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                m_tick = (m_st[k] == M_RUN) && (m_cnt[k] == div_of(k) - 1);
                m_want = m_tick && (!change_of(k) || (p2 != m_last[k]));
                m_pop  = rd_en && (q_size(k) > 0);
                m_full = (q_size(k) == DEPTH);
                m_drop = 1'b0;
                if (m_pop) q_pop(k);
                if (m_want) begin
                    if (!m_full || m_pop) begin
                        q_push(k, {4'(m_seq[k]), p2});
                        m_seq[k]  = (m_seq[k] + 1) % 16;
                        m_last[k] = p2;
                    end else begin
                        m_drop   = 1'b1;
                        m_ovf[k] = 1'b1;
                    end
                end
                if (m_st[k] == M_RUN) m_cnt[k] = m_tick ? 0 : m_cnt[k] + 1;
                if (stop) m_st[k] = M_IDLE;
                else if (arm && m_st[k] != M_RUN) begin
                    m_st[k] = M_RUN; q_clear(k); m_ovf[k] = 1'b0;
                    m_seq[k] = 0; m_cnt[k] = 0; m_last[k] = p2;
                end else if (m_st[k] == M_RUN && m_drop) m_st[k] = M_HALT;
                if (m_st[k] != M_RUN) m_cnt[k] = 0;
            end
            p2 = p1;
            p1 = d_in;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(1); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; stop = 1'b0; rd_en = 1'b0; d_in = 12'($urandom);
        step(3);
        for (int k = 0; k < N; k++) begin
            total++; if (rd_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_rd_valid dut%0d got=%b exp=0", k, rd_valid[k]); end
            total++; if (level[k] !== '0) begin bad++; $display("FAIL reset_level dut%0d got=%0d exp=0", k, level[k]); end
            total++; if (overflow[k] !== 1'b0) begin bad++; $display("FAIL reset_overflow dut%0d got=%b exp=0", k, overflow[k]); end
            total++; if (running[k] !== 1'b0) begin bad++; $display("FAIL reset_running dut%0d got=%b exp=0", k, running[k]); end
            total++; if (rd_data[k] !== 16'h0) begin bad++; $display("FAIL reset_rd_data dut%0d got=%h exp=0000", k, rd_data[k]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        d_in = 12'h5A5;
        pulse_stop(); step(3);
        pulse_arm(); step(20);
        total++; if (level[0] !== LW'(5)) begin bad++; $display("FAIL cont_level got=%0d exp=5", level[0]); end
        total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL cont_running got=%b exp=1", running[0]); end
        pulse_stop();
        for (int i = 0; i < 5; i++) begin
            total++; if (rd_data[0] !== {4'(i), 12'h5A5}) begin bad++; $display("FAIL cont_word%0d got=%h exp=%h", i, rd_data[0], {4'(i), 12'h5A5}); end
            rd_en = 1'b1; step(1); rd_en = 1'b0;
        end
        total++; if (rd_valid[0] !== 1'b0) begin bad++; $display("FAIL cont_drained got=%b exp=0", rd_valid[0]); end
    endtask

    task automatic test_change_only();
        d_in = 12'h000;
        pulse_stop(); step(3);
        pulse_arm(); step(10);
        d_in = 12'h001; step(10);
        d_in = 12'h003; step(10);
        pulse_stop();
        total++; if (level[2] !== LW'(2)) begin bad++; $display("FAIL chg_level got=%0d exp=2", level[2]); end
        total++; if (rd_data[2] !== 16'h0001) begin bad++; $display("FAIL chg_word0 got=%h exp=0001", rd_data[2]); end
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        total++; if (rd_data[2] !== 16'h1003) begin bad++; $display("FAIL chg_word1 got=%h exp=1003", rd_data[2]); end
        rd_en = 1'b1; step(1); rd_en = 1'b0;
        total++; if (rd_valid[2] !== 1'b0) begin bad++; $display("FAIL chg_drained got=%b exp=0", rd_valid[2]); end
    endtask

    task automatic test_overflow();
        logic [11:0] smp;
        smp = 12'($urandom);
        d_in = smp;
        pulse_stop(); step(3);
        pulse_arm(); step(16);
        total++; if (level[1] !== LW'(16)) begin bad++; $display("FAIL ovf_full_level got=%0d exp=16", level[1]); end
        total++; if (overflow[1] !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow[1]); end
        step(1);
        total++; if (overflow[1] !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow[1]); end
        total++; if (running[1] !== 1'b0) begin bad++; $display("FAIL ovf_halt got=%b exp=0", running[1]); end
        step(3);
        total++; if (level[1] !== LW'(16)) begin bad++; $display("FAIL ovf_halt_level got=%0d exp=16", level[1]); end
        for (int i = 0; i < 15; i++) begin
            total++; if (rd_data[1] !== {4'(i), smp}) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, rd_data[1], {4'(i), smp}); end
            rd_en = 1'b1; step(1); rd_en = 1'b0;
        end
        total++; if (rd_data[1] !== {4'hF, smp}) begin bad++; $display("FAIL ovf_last_word got=%h exp=%h", rd_data[1], {4'hF, smp}); end
        pulse_arm();
        total++; if (level[1] !== '0) begin bad++; $display("FAIL rearm_level got=%0d exp=0", level[1]); end
        total++; if (overflow[1] !== 1'b0) begin bad++; $display("FAIL rearm_overflow got=%b exp=0", overflow[1]); end
        step(1);
        total++; if (rd_data[1] !== {4'h0, smp}) begin bad++; $display("FAIL rearm_seq got=%h exp=%h", rd_data[1], {4'h0, smp}); end
    endtask

    task automatic test_full_pop();
        logic [11:0] smp;
        smp = 12'($urandom);
        d_in = smp;
        pulse_stop(); step(3);
        pulse_arm(); step(16);
        total++; if (level[1] !== LW'(16)) begin bad++; $display("FAIL fullpop_fill got=%0d exp=16", level[1]); end
        rd_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step(1);
            total++; if (level[1] !== LW'(16)) begin bad++; $display("FAIL fullpop_level%0d got=%0d exp=16", j, level[1]); end
            total++; if (overflow[1] !== 1'b0) begin bad++; $display("FAIL fullpop_ovf%0d got=%b exp=0", j, overflow[1]); end
            total++; if (rd_data[1] !== {4'((j + 1) % 16), smp}) begin bad++; $display("FAIL fullpop_head%0d got=%h exp=%h", j, rd_data[1], {4'((j + 1) % 16), smp}); end
        end
        stop = 1'b1; step(1); stop = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_pop_empty();
        logic [11:0] smp;
        rst = 1'b1; step(1); rst = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1);
            total++; if (rd_valid[0] !== 1'b0) begin bad++; $display("FAIL empty_valid%0d got=%b exp=0", i, rd_valid[0]); end
            total++; if (level[0] !== '0) begin bad++; $display("FAIL empty_level%0d got=%0d exp=0", i, level[0]); end
        end
        rd_en = 1'b0;
        smp = 12'($urandom);
        d_in = smp;
        step(3);
        pulse_arm(); step(4);
        total++; if (level[0] !== LW'(1)) begin bad++; $display("FAIL empty_push_level got=%0d exp=1", level[0]); end
        total++; if (rd_data[0] !== {4'h0, smp}) begin bad++; $display("FAIL empty_push_word got=%h exp=%h", rd_data[0], {4'h0, smp}); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] smp;
        smp = 12'($urandom);
        d_in = smp;
        pulse_stop(); step(3);
        pulse_arm(); step(12);
        total++; if (level[0] !== LW'(3)) begin bad++; $display("FAIL mid_level got=%0d exp=3", level[0]); end
        rst = 1'b1; step(1); rst = 1'b0;
        for (int k = 0; k < N; k++) begin
            total++; if (level[k] !== '0) begin bad++; $display("FAIL mid_rst_level dut%0d got=%0d exp=0", k, level[k]); end
            total++; if (rd_valid[k] !== 1'b0) begin bad++; $display("FAIL mid_rst_valid dut%0d got=%b exp=0", k, rd_valid[k]); end
            total++; if (running[k] !== 1'b0) begin bad++; $display("FAIL mid_rst_running dut%0d got=%b exp=0", k, running[k]); end
            total++; if (overflow[k] !== 1'b0) begin bad++; $display("FAIL mid_rst_overflow dut%0d got=%b exp=0", k, overflow[k]); end
        end
        step(3);
        pulse_arm(); step(4);
        total++; if (rd_data[0] !== {4'h0, smp}) begin bad++; $display("FAIL mid_rearm_word got=%h exp=%h", rd_data[0], {4'h0, smp}); end
    endtask

    task automatic test_random();
        int pop_pct;
        rst = 1'b1; step(1); rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            pop_pct = ((c / 100) % 2 == 0) ? 15 : 70;
            if ($urandom_range(0, 3) == 0) d_in = 12'($urandom_range(0, 7));
            rd_en = ($urandom_range(0, 99) < pop_pct);
            arm   = ($urandom_range(0, 39) == 0);
            stop  = ($urandom_range(0, 119) == 0);
            step(1);
            for (int k = 0; k < N; k++) begin
                total++; if (level[k] !== LW'(q_size(k))) begin bad++; $display("FAIL rand_level dut%0d cyc%0d got=%0d exp=%0d", k, c, level[k], q_size(k)); end
                total++; if (rd_valid[k] !== (q_size(k) > 0)) begin bad++; $display("FAIL rand_valid dut%0d cyc%0d got=%b exp=%b", k, c, rd_valid[k], q_size(k) > 0); end
                total++; if (rd_data[k] !== q_head(k)) begin bad++; $display("FAIL rand_data dut%0d cyc%0d got=%h exp=%h", k, c, rd_data[k], q_head(k)); end
                total++; if (overflow[k] !== m_ovf[k]) begin bad++; $display("FAIL rand_overflow dut%0d cyc%0d got=%b exp=%b", k, c, overflow[k], m_ovf[k]); end
                total++; if (running[k] !== (m_st[k] == M_RUN)) begin bad++; $display("FAIL rand_running dut%0d cyc%0d got=%b exp=%b", k, c, running[k], m_st[k] == M_RUN); end
            end
        end
        arm = 1'b0; stop = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_change_only();
        test_overflow();
        test_full_pop();
        test_pop_empty();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
